pipe_hazard_ctrl: RTL and testbench

Sequencing and hazard controller for the 3-stage pipeline (IF → DE/EX → MEM/WB). It sits beside the instruction decoder and register file. It decides each cycle whether the pipeline advances, holds, or flushes:
- generates register-operand forwarding selects,
- runs the data-memory request/acknowledge handshake for loads and stores,
- kills the wrong-path fetch on a taken branch or jump,
- latches a sticky error if data memory never acknowledges.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/reg_use_decode.sv | 15 +
 rtl/pipe_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes and FSM state type for the pipeline sequencing/hazard controller.
package pipe_ctrl_pkg;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcIAlu   = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StErr     = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/reg_use_decode.sv
// Opcode to source-register usage decode; shared with the instruction decoder.
module reg_use_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       rs1_used,
  output logic       rs2_used
);

  always_comb begin
    rs1_used = !((opcode == OpcLui) || (opcode == OpcAuipc) || (opcode == OpcJal));
    rs2_used = (opcode == OpcR) || (opcode == OpcStore) || (opcode == OpcBranch);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Advance/hold/flush control for the 3-stage pipeline: forwarding, dmem handshake, timeout.
// Build option: PIPE_FWD_EN enables WB->DE forwarding instead of hazard bubbles.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode_de,
  input  logic [4:0] rs1_de,
  input  logic [4:0] rs2_de,
  input  logic [4:0] rd_wb,
  input  logic       reg_wr_wb,
  input  logic       mem_op_wb,
  input  logic       br_taken_de,
  input  logic       dmem_ack,
  output logic       dmem_req,
  output logic       stall_fe,
  output logic       hold_wb,
  output logic       bubble_wb,
  output logic       flush_de,
  output logic       fwd_a,
  output logic       fwd_b,
  output logic       mem_timeout
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic             rs1_used, rs2_used;
  logic             haz_a, haz_b;
  logic             mem_stall, data_stall, stall;
  logic             req;
  pipe_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  reg_use_decode u_reg_use_decode (
    .opcode   (opcode_de),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  assign haz_a = rs1_used && reg_wr_wb && (rd_wb != 5'd0) && (rd_wb == rs1_de);
  assign haz_b = rs2_used && reg_wr_wb && (rd_wb != 5'd0) && (rd_wb == rs2_de);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (mem_op_wb && !dmem_ack) begin
            state_q <= StMemWait;
            cnt_q   <= CNT_W'(1);
          end
        end
        StMemWait: begin
          if (dmem_ack) begin
            state_q <= StRun;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
            state_q   <= StErr;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StErr: begin
          // Sticky until reset.
          state_q <= StErr;
        end
        default: begin
          state_q <= StRun;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    req       = 1'b0;
    mem_stall = 1'b0;
    case (state_q)
      StRun: begin
        req       = mem_op_wb;
        mem_stall = mem_op_wb && !dmem_ack;
      end
      StMemWait: begin
        req       = 1'b1;
        mem_stall = !dmem_ack;
      end
      StErr: begin
        mem_stall = 1'b1;
      end
      default: begin
        req       = 1'b0;
        mem_stall = 1'b0;
      end
    endcase

`ifdef PIPE_FWD_EN
    data_stall = 1'b0;
    fwd_a      = haz_a;
    fwd_b      = haz_b;
`else
    // Memory stall takes priority; the hazard is seen again once it releases.
    data_stall = (haz_a || haz_b) && !mem_stall;
    fwd_a      = 1'b0;
    fwd_b      = 1'b0;
`endif

    stall       = mem_stall || data_stall;
    dmem_req    = req;
    stall_fe    = stall;
    hold_wb     = mem_stall;
    bubble_wb   = data_stall;
    flush_de    = br_taken_de && !stall;
    mem_timeout = timeout_q;

    if (rst) begin
      dmem_req    = 1'b0;
      stall_fe    = 1'b0;
      hold_wb     = 1'b0;
      bubble_wb   = 1'b0;
      flush_de    = 1'b0;
      fwd_a       = 1'b0;
      fwd_b       = 1'b0;
      mem_timeout = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven bench for pipe_hazard_ctrl with a scoreboard queue; honours PIPE_FWD_EN.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

`ifdef PIPE_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  // Expected-output bit positions.
  localparam logic [7:0] EReq   = 8'h80;
  localparam logic [7:0] EStall = 8'h40;
  localparam logic [7:0] EHold  = 8'h20;
  localparam logic [7:0] EBub   = 8'h10;
  localparam logic [7:0] EFlush = 8'h08;
  localparam logic [7:0] EFa    = 8'h04;
  localparam logic [7:0] EFb    = 8'h02;
  localparam logic [7:0] ETo    = 8'h01;
  localparam logic [7:0] EMem   = EReq | EStall | EHold;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       wr;
    logic       memop;
    logic       br;
    logic       ack;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode_de = '0;
  logic [4:0] rs1_de = '0, rs2_de = '0, rd_wb = '0;
  logic       reg_wr_wb = 1'b0, mem_op_wb = 1'b0, br_taken_de = 1'b0, dmem_ack = 1'b0;
  logic       dmem_req, stall_fe, hold_wb, bubble_wb, flush_de, fwd_a, fwd_b, mem_timeout;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  string      name_q[$];
  vec_t       tbl[$];

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode_de   (opcode_de),
    .rs1_de      (rs1_de),
    .rs2_de      (rs2_de),
    .rd_wb       (rd_wb),
    .reg_wr_wb   (reg_wr_wb),
    .mem_op_wb   (mem_op_wb),
    .br_taken_de (br_taken_de),
    .dmem_ack    (dmem_ack),
    .dmem_req    (dmem_req),
    .stall_fe    (stall_fe),
    .hold_wb     (hold_wb),
    .bubble_wb   (bubble_wb),
    .flush_de    (flush_de),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .mem_timeout (mem_timeout)
  );

  always #5 clk = ~clk;

  // Expected outputs for a data hazard with no memory stall.
  function automatic logic [7:0] hz(input bit fa, input bit fb);
    if (FwdEn) return (fa ? EFa : 8'h00) | (fb ? EFb : 8'h00);
    return (fa || fb) ? (EStall | EBub) : 8'h00;
  endfunction

  function automatic vec_t mk(input string name, input logic [6:0] op, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd, input logic wr,
                              input logic memop, input logic br, input logic ack,
                              input logic [7:0] exp);
    vec_t v;
    v.name = name; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.wr = wr;
    v.memop = memop; v.br = br; v.ack = ack; v.exp = exp;
    return v;
  endfunction

  // Drive one cycle of inputs, sample outputs at the falling edge, then move past the next rise.
  task automatic step(input vec_t v);
    logic [7:0] got, exp;
    string      nm;
    opcode_de = v.op; rs1_de = v.rs1; rs2_de = v.rs2; rd_wb = v.rd;
    reg_wr_wb = v.wr; mem_op_wb = v.memop; br_taken_de = v.br; dmem_ack = v.ack;
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
    @(negedge clk);
    got = {dmem_req, stall_fe, hold_wb, bubble_wb, flush_de, fwd_a, fwd_b, mem_timeout};
    exp = exp_q.pop_front();
    nm  = name_q.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got req/stall/hold/bub/flush/fa/fb/to=%b required %b", nm, got, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with busy inputs: everything must read 0.
    step(mk("rst_outputs", OpcR, 5'd5, 5'd5, 5'd5, 1, 1, 1, 0, 8'h00));
    step(mk("rst_outputs2", OpcStore, 5'd3, 5'd7, 5'd7, 1, 1, 1, 1, 8'h00));
    rst = 1'b0;

    tbl.push_back(mk("idle", OpcR, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk("fwd_ab", OpcR, 5'd5, 5'd5, 5'd5, 1, 0, 0, 0, hz(1, 1)));
    tbl.push_back(mk("rd_x0", OpcR, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 8'h00));
    tbl.push_back(mk("ialu_no_rs2", OpcIAlu, 5'd1, 5'd7, 5'd7, 1, 0, 0, 0, 8'h00));
    tbl.push_back(mk("store_rs2", OpcStore, 5'd1, 5'd7, 5'd7, 1, 0, 0, 0, hz(0, 1)));
    tbl.push_back(mk("branch_rs2", OpcBranch, 5'd2, 5'd9, 5'd9, 1, 0, 0, 0, hz(0, 1)));
    tbl.push_back(mk("ialu_rs1", OpcIAlu, 5'd3, 5'd0, 5'd3, 1, 0, 0, 0, hz(1, 0)));
    tbl.push_back(mk("no_wr", OpcIAlu, 5'd3, 5'd0, 5'd3, 0, 0, 0, 0, 8'h00));
    tbl.push_back(mk("lui_no_rs1", OpcLui, 5'd3, 5'd3, 5'd3, 1, 0, 0, 0, 8'h00));
    tbl.push_back(mk("auipc_no_rs1", OpcAuipc, 5'd3, 5'd3, 5'd3, 1, 0, 0, 0, 8'h00));
    tbl.push_back(mk("jal_no_rs1", OpcJal, 5'd3, 5'd3, 5'd3, 1, 0, 0, 0, 8'h00));
    tbl.push_back(mk("jalr_rs1", OpcJalr, 5'd3, 5'd3, 5'd3, 1, 0, 0, 0, hz(1, 0)));
    tbl.push_back(mk("load_rs1", OpcLoad, 5'd4, 5'd4, 5'd4, 1, 0, 0, 0, hz(1, 0)));
    tbl.push_back(mk("src_x0", OpcR, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 8'h00));
    tbl.push_back(mk("flush", OpcBranch, 5'd1, 5'd2, 5'd3, 1, 0, 1, 0, EFlush));
    tbl.push_back(mk("flush_vs_haz", OpcJalr, 5'd3, 5'd0, 5'd3, 1, 0, 1, 0,
                     FwdEn ? (EFlush | EFa) : (EStall | EBub)));
    tbl.push_back(mk("ack_no_req", OpcR, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 8'h00));
    tbl.push_back(mk("zero_wait", OpcR, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, EReq));
    tbl.push_back(mk("after_zw", OpcR, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 8'h00));
    foreach (tbl[i]) step(tbl[i]);

    // Memory access acknowledged on the 4th request cycle.
    for (int i = 0; i < 3; i++) step(mk("mwait_stall", OpcR, 0, 0, 0, 0, 1, 0, 0, EMem));
    step(mk("mwait_ack", OpcR, 0, 0, 0, 0, 1, 0, 1, EReq));
    step(mk("mwait_back_run", OpcR, 0, 0, 0, 0, 0, 0, 0, 8'h00));

    // Taken branch held across a 2-cycle memory stall.
    for (int i = 0; i < 2; i++) step(mk("br_in_stall", OpcJal, 0, 0, 0, 0, 1, 1, 0, EMem));
    step(mk("br_release", OpcJal, 0, 0, 0, 0, 1, 1, 1, EReq | EFlush));
    step(mk("br_done", OpcR, 0, 0, 0, 0, 0, 0, 0, 8'h00));

    // Data hazard coinciding with a memory stall.
    step(mk("haz_in_mstall", OpcIAlu, 5'd3, 0, 5'd3, 1, 1, 0, 0, EMem | (FwdEn ? EFa : 8'h00)));
    step(mk("haz_at_release", OpcIAlu, 5'd3, 0, 5'd3, 1, 1, 0, 1, EReq | hz(1, 0)));
    step(mk("haz_cleared", OpcIAlu, 5'd3, 0, 5'd3, 0, 0, 0, 0, 8'h00));

    // Timeout after exactly 4 unacknowledged wait cycles, then sticky.
    step(mk("to_enter", OpcR, 0, 0, 0, 0, 1, 0, 0, EMem));
    for (int i = 0; i < 4; i++) step(mk("to_waiting", OpcR, 0, 0, 0, 0, 1, 0, 0, EMem));
    step(mk("to_err", OpcR, 0, 0, 0, 0, 1, 0, 0, EStall | EHold | ETo));
    step(mk("to_err_ack", OpcR, 0, 0, 0, 0, 1, 1, 1, EStall | EHold | ETo));
    step(mk("to_err_idle", OpcR, 0, 0, 0, 0, 0, 0, 0, EStall | EHold | ETo));
    rst = 1'b1;
    step(mk("rst_in_err", OpcR, 0, 0, 0, 0, 1, 1, 0, 8'h00));
    rst = 1'b0;
    step(mk("after_err_rst", OpcR, 0, 0, 0, 0, 0, 0, 0, 8'h00));

    // Reset in the middle of a memory wait.
    step(mk("mw_enter", OpcR, 0, 0, 0, 0, 1, 0, 0, EMem));
    step(mk("mw_wait", OpcR, 0, 0, 0, 0, 1, 0, 0, EMem));
    rst = 1'b1;
    step(mk("rst_mid_wait", OpcR, 5'd3, 0, 5'd3, 1, 1, 1, 0, 8'h00));
    rst = 1'b0;
    step(mk("run_after_rst", OpcR, 0, 0, 0, 0, 0, 0, 0, 8'h00));
    step(mk("mw2_enter", OpcR, 0, 0, 0, 0, 1, 0, 0, EMem));
    step(mk("mw2_ack", OpcR, 0, 0, 0, 0, 1, 0, 1, EReq));
    step(mk("mw2_done", OpcR, 0, 0, 0, 0, 0, 0, 0, 8'h00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
